// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encodings, default frame marker, count width.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         CNT_W             = 9;

endpackage

// File: rtl/loader_csum8.sv
// Modulo-256 byte accumulator; isZero reports whether sum+data (the byte now presented) wraps to zero.
module loader_csum8 (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic       isZero
);

  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (!resetN)    sum <= '0;
    else if (clear) sum <= '0;
    else if (add)   sum <= sum + data;
  end

  // Look-ahead test lets the caller decide in the same cycle the final byte arrives.
  assign isZero = ((sum + data) == 8'h00);

endmodule

// File: rtl/program_loader.sv
// Framed host-to-program-memory loader (SYNC, LEN, data, CSUM); holds the CPU while loading.
// Optional readback verification after a good checksum is enabled by defining LOADER_VERIFY_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [7:0]        SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  output logic              rxReady,
  output logic [ADDR_W-1:0] memWrAddr,
  output logic [7:0]        memWrData,
  output logic              memWrStrobe,
  output logic [ADDR_W-1:0] memRdAddr,
  output logic              memRdStrobe,
  input  logic [7:0]        memRdData,
  output logic              cpuHold,
  output logic              loadDone,
  output logic              loadError
);

  state_t            state, stateNext;
  logic              readyEn;
  logic [CNT_W-1:0]  count, index;
  logic              acc, frameStart, lastData, rxSumZero;
  logic              wrVld_p1;
  logic [ADDR_W-1:0] wrAddr_p1;
  logic [7:0]        wrData_p1;

  assign acc        = rxValid && rxReady;
  assign frameStart = acc && (rxData == SYNC_BYTE) &&
                      (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign lastData   = ((index + CNT_W'(1)) == count);

  loader_csum8 uRxSum (
    .clk    (clk),
    .resetN (resetN),
    .clear  (frameStart),
    .add    (acc && (state == ST_DATA)),
    .data   (rxData),
    .isZero (rxSumZero)
  );

`ifdef LOADER_VERIFY_EN
  localparam state_t CSUM_OK_STATE = ST_VERIFY;

  logic [7:0] rxCsum;
  logic       rdVld_p1, rdSumZero, rdAdd;
  logic [7:0] rdIn;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rxCsum   <= '0;
      rdVld_p1 <= 1'b0;
    end else begin
      rdVld_p1 <= memRdStrobe;
      if (acc && state == ST_CSUM) rxCsum <= rxData;
    end
  end

  // First verify cycle has no read data yet, so it seeds the sum with the received checksum.
  assign rdAdd = (state == ST_VERIFY) && (rdVld_p1 || index == '0);
  assign rdIn  = rdVld_p1 ? memRdData : rxCsum;

  loader_csum8 uRdSum (
    .clk    (clk),
    .resetN (resetN),
    .clear  (frameStart),
    .add    (rdAdd),
    .data   (rdIn),
    .isZero (rdSumZero)
  );
`else
  localparam state_t CSUM_OK_STATE = ST_DONE;

  logic unusedRdData;
  assign unusedRdData = ^memRdData;
`endif

  always_ff @(posedge clk) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (frameStart) stateNext = ST_LEN;
      ST_LEN:  if (acc) stateNext = ST_DATA;
      ST_DATA: if (acc && lastData) stateNext = ST_CSUM;
      ST_CSUM: if (acc) stateNext = rxSumZero ? CSUM_OK_STATE : ST_ERROR;
`ifdef LOADER_VERIFY_EN
      ST_VERIFY: if (index == count) stateNext = rdSumZero ? ST_DONE : ST_ERROR;
`endif
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    rxReady     = readyEn;
    cpuHold     = 1'b0;
    loadDone    = 1'b0;
    loadError   = 1'b0;
    memRdStrobe = 1'b0;
    memRdAddr   = '0;
    case (state)
      ST_LEN, ST_DATA, ST_CSUM: cpuHold = 1'b1;
`ifdef LOADER_VERIFY_EN
      ST_VERIFY: begin
        rxReady = 1'b0;
        cpuHold = 1'b1;
        if (index < count) begin
          memRdStrobe = 1'b1;
          memRdAddr   = START_ADDR + ADDR_W'(index);
        end
      end
`endif
      ST_DONE:  loadDone = 1'b1;
      ST_ERROR: begin
        loadError = 1'b1;
        cpuHold   = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p1: accepted data byte becomes a memory write one cycle later.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      readyEn   <= 1'b0;
      count     <= '0;
      index     <= '0;
      wrVld_p1  <= 1'b0;
      wrAddr_p1 <= '0;
      wrData_p1 <= '0;
    end else begin
      readyEn  <= 1'b1;
      wrVld_p1 <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: if (frameStart) index <= '0;
        ST_LEN: if (acc) count <= (rxData == 8'h00) ? CNT_W'(256) : CNT_W'(rxData);
        ST_DATA: if (acc) begin
          wrVld_p1  <= 1'b1;
          wrAddr_p1 <= START_ADDR + ADDR_W'(index);
          wrData_p1 <= rxData;
          index     <= index + CNT_W'(1);
        end
        ST_CSUM: if (acc) index <= '0;
`ifdef LOADER_VERIFY_EN
        ST_VERIFY: index <= index + CNT_W'(1);
`endif
        default: ;
      endcase
    end
  end

  assign memWrStrobe = wrVld_p1;
  assign memWrAddr   = wrAddr_p1;
  assign memWrData   = wrData_p1;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: write scoreboard with exact-cycle checks, status checks per frame.
module tb_program_loader;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] rxData0 = '0, rxDataF = '0;
  logic       rxValid0 = 1'b0, rxValidF = 1'b0;
  logic       rxReady0, rxReadyF;
  logic [7:0] memWrAddr0, memWrData0, memWrAddrF, memWrDataF;
  logic       memWrStrobe0, memWrStrobeF;
  logic [7:0] memRdAddr0, memRdAddrF;
  logic       memRdStrobe0, memRdStrobeF;
  logic [7:0] memRdData0 = '0, memRdDataF = '0;
  logic       cpuHold0, cpuHoldF, loadDone0, loadDoneF, loadError0, loadErrorF;

  int  chkCnt = 0, passCnt = 0, failCnt = 0;
  int  cyc = 0;
  bit  corrupt = 1'b0;
  wr_t q0[$], qF[$];
  logic [7:0] mem0 [256];
  logic [7:0] memF [256];

  program_loader dut (
    .clk(clk), .resetN(resetN), .rxData(rxData0), .rxValid(rxValid0), .rxReady(rxReady0),
    .memWrAddr(memWrAddr0), .memWrData(memWrData0), .memWrStrobe(memWrStrobe0),
    .memRdAddr(memRdAddr0), .memRdStrobe(memRdStrobe0), .memRdData(memRdData0),
    .cpuHold(cpuHold0), .loadDone(loadDone0), .loadError(loadError0)
  );

  program_loader #(.START_ADDR(8'hFE)) dutF (
    .clk(clk), .resetN(resetN), .rxData(rxDataF), .rxValid(rxValidF), .rxReady(rxReadyF),
    .memWrAddr(memWrAddrF), .memWrData(memWrDataF), .memWrStrobe(memWrStrobeF),
    .memRdAddr(memRdAddrF), .memRdStrobe(memRdStrobeF), .memRdData(memRdDataF),
    .cpuHold(cpuHoldF), .loadDone(loadDoneF), .loadError(loadErrorF)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program memory models; the first one can corrupt address 01 on readback.
  initial for (int i = 0; i < 256; i++) begin mem0[i] = '0; memF[i] = '0; end
  always @(posedge clk) begin
    if (memWrStrobe0) mem0[memWrAddr0] <= memWrData0;
    if (memWrStrobeF) memF[memWrAddrF] <= memWrDataF;
    memRdData0 <= mem0[memRdAddr0] ^ ((corrupt && memRdAddr0 == 8'h01) ? 8'h01 : 8'h00);
    memRdDataF <= memF[memRdAddrF];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (memWrStrobe0) begin
      chk("wrExpected0", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("wrAddr0", memWrAddr0, e.addr);
        chk("wrData0", memWrData0, e.data);
        chk("wrCycle0", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (memWrStrobeF) begin
      chk("wrExpectedF", qF.size() != 0, 1);
      if (qF.size() != 0) begin
        e = qF.pop_front();
        chk("wrAddrF", memWrAddrF, e.addr);
        chk("wrDataF", memWrDataF, e.data);
        chk("wrCycleF", cyc, e.cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 of the edge that transferred the byte.
  task automatic sendByte(input bit inst, input logic [7:0] b, input bit gaps,
                          input bit isData, input logic [7:0] addr);
    wr_t e;
    bit  ok;
    ok = 1'b0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    if (inst) begin rxDataF = b; rxValidF = 1'b1; end
    else      begin rxData0 = b; rxValid0 = 1'b1; end
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = inst ? rxReadyF : rxReady0;
    end
    chk("rxReadyWait", ok, 1);
    @(posedge clk);
    #1;
    if (isData) begin
      e = '{addr: addr, data: b, cyc: cyc};
      if (inst) qF.push_back(e);
      else      q0.push_back(e);
    end
    if (inst) rxValidF = 1'b0;
    else      rxValid0 = 1'b0;
  endtask

  task automatic sendFrame(input bit inst, input logic [7:0] fr[$],
                           input logic [7:0] start, input bit gaps);
    for (int i = 0; i < fr.size(); i++) begin
      sendByte(inst, fr[i], gaps, (i >= 2) && (i < fr.size() - 1), start + 8'(i - 2));
      if (i == 0) begin
        @(negedge clk);
        chk("cpuHoldLoading", inst ? cpuHoldF : cpuHold0, 1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic finishFrame(input bit inst, input bit csumOk, input bit verifyOk, input int cnt);
    bit ok;
    ok = csumOk && verifyOk;
`ifdef LOADER_VERIFY_EN
    if (csumOk)
      for (int i = 0; i < cnt + 1; i++) begin
        @(negedge clk);
        chk("verifyBusy", inst ? rxReadyF : rxReady0, 0);
      end
`endif
    @(negedge clk);
    chk("loadDone",  inst ? loadDoneF  : loadDone0,  ok);
    chk("loadError", inst ? loadErrorF : loadError0, !ok);
    chk("cpuHold",   inst ? cpuHoldF   : cpuHold0,   !ok);
    chk("rxReadyEnd", inst ? rxReadyF  : rxReady0,   1);
    chk("wrDrained", inst ? qF.size()  : q0.size(),  0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fr[$];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("resetOut0", {rxReady0, memWrStrobe0, memWrAddr0, memWrData0, memRdStrobe0,
                      memRdAddr0, cpuHold0, loadDone0, loadError0}, 0);
    chk("resetOutF", {rxReadyF, memWrStrobeF, memWrAddrF, memWrDataF, memRdStrobeF,
                      memRdAddrF, cpuHoldF, loadDoneF, loadErrorF}, 0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("readyAfterReset", rxReady0, 1);
    @(posedge clk);
    #1;

    // Basic frame preceded by a dropped non-sync byte
    sendByte(1'b0, 8'h11, 1'b0, 1'b0, 8'h00);
    fr = '{8'hA5, 8'h03, 8'h0F, 8'hFF, 8'h01, 8'hF1};
    sendFrame(1'b0, fr, 8'h00, 1'b0);
    finishFrame(1'b0, 1'b1, 1'b1, 3);

    // Bad checksum, then recovery frame
    fr = '{8'hA5, 8'h03, 8'h0F, 8'hFF, 8'h01, 8'hF2};
    sendFrame(1'b0, fr, 8'h00, 1'b0);
    finishFrame(1'b0, 1'b0, 1'b1, 3);
    fr = '{8'hA5, 8'h01, 8'h07, 8'hF9};
    sendFrame(1'b0, fr, 8'h00, 1'b0);
    finishFrame(1'b0, 1'b1, 1'b1, 1);

    // Address wrap on the FE-based instance; SYNC value as data
    fr = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    sendFrame(1'b1, fr, 8'hFE, 1'b0);
    finishFrame(1'b1, 1'b1, 1'b1, 3);
    fr = '{8'hA5, 8'h02, 8'hA5, 8'h10, 8'h4B};
    sendFrame(1'b1, fr, 8'hFE, 1'b0);
    finishFrame(1'b1, 1'b1, 1'b1, 2);

    // LEN=0 means 256 bytes, straight and with random valid gaps
    fr = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) fr.push_back(8'h01);
    fr.push_back(8'h00);
    sendFrame(1'b0, fr, 8'h00, 1'b0);
    finishFrame(1'b0, 1'b1, 1'b1, 256);
    sendFrame(1'b0, fr, 8'h00, 1'b1);
    finishFrame(1'b0, 1'b1, 1'b1, 256);

    // Reset after the second data byte of a 4-byte frame
    sendByte(1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    sendByte(1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    sendByte(1'b0, 8'h10, 1'b0, 1'b1, 8'h00);
    sendByte(1'b0, 8'h20, 1'b0, 1'b1, 8'h01);
    resetN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midResetOut", {rxReady0, memWrStrobe0, memWrAddr0, memWrData0, memRdStrobe0,
                        memRdAddr0, cpuHold0, loadDone0, loadError0}, 0);
    chk("midResetQueue", q0.size(), 0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    fr = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h89};
    sendFrame(1'b0, fr, 8'h00, 1'b0);
    finishFrame(1'b0, 1'b1, 1'b1, 2);

`ifdef LOADER_VERIFY_EN
    // Readback verify against a corrupting and then a clean memory
    corrupt = 1'b1;
    fr = '{8'hA5, 8'h03, 8'h0F, 8'hFF, 8'h01, 8'hF1};
    sendFrame(1'b0, fr, 8'h00, 1'b0);
    finishFrame(1'b0, 1'b1, 1'b0, 3);
    corrupt = 1'b0;
    sendFrame(1'b0, fr, 8'h00, 1'b0);
    finishFrame(1'b0, 1'b1, 1'b1, 3);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passCnt, chkCnt);
    $finish;
  end

endmodule
